debug_loader: RTL and testbench
===============================

# debug_loader

Front-end controller that sits directly upstream of the instruction-fetch stage. It assembles 32-bit instructions from a byte stream (UART receiver side) and drives the fetch stage's instruction-write data/strobe. It also gates the fetch stage's PC enable for continuous-run and single-step execution. While it is loading, the pipeline is frozen, so the fetch stage's `write & ~enable` qualification always passes.

## Interface
- `SIZE_REG_MEM`, 32, instruction word width
- `SIZE_BYTE`, 8, received byte width
- `MAX_INSTR`, 256, program memory capacity in words
- `SIZE_CNT`, 9, instruction counter width (must hold `MAX_INSTR`)
- `HALT_WORD`, 32'hFFFF_FFFF, terminating instruction encoding
- `i_clk`  in  1  single clock, all state on rising edge
- `i_reset`  in  1  asynchronous, active-high; clears all state
- `i_rx_data`  in  `SIZE_BYTE`  received byte
- `i_rx_valid`  in  1  one-cycle pulse, `i_rx_data` valid
- `i_halt_detected`  in  1  pipeline reached `HALT_WORD` in writeback
- `o_instruction_write`  out  `SIZE_REG_MEM`  assembled instruction to program memory
- `o_flag_instruction_write`  out  1  one-cycle write strobe
- `o_enable`  out  1  PC/pipeline enable
- `o_instr_count`  out  `SIZE_CNT`  words written in current load
- `o_loaded`  out  1  a complete program (ending in `HALT_WORD`) is present
- `o_busy`  out  1  state != IDLE
- `o_error`  out  1  sticky error flag

## Operation
- States: IDLE, LOAD, WRITE, RUN, STEP.
- **IDLE:** a byte with `i_rx_valid` is a command.
  - 0x4C 'L': clear count, `o_loaded`, `o_error` and the byte index → LOAD.
  - 0x52 'R' with `o_loaded`=1 → RUN.
  - 0x53 'S' with `o_loaded`=1 → STEP.
  - 'R'/'S' while `o_loaded`=0, or any other byte: set `o_error`, stay IDLE.
- **LOAD:** each valid byte shifts into the word register, first byte = MSB (big-endian). A 2-bit byte index wraps 3→0. The 4th byte → WRITE.
- **WRITE** (exactly one cycle):
  - `o_flag_instruction_write`=1 and `o_instruction_write` holds the assembled word.
  - The count increments at the end of the cycle.
  - If word == `HALT_WORD`: set `o_loaded` → IDLE.
  - Else if the new count == `MAX_INSTR`: set `o_error`, `o_loaded`=0 → IDLE.
  - Else → LOAD.
  - A byte with `i_rx_valid` during WRITE is captured as byte 0 of the next word, so back-to-back bytes are never dropped.
- **RUN:** `o_enable`=1 every cycle. `i_halt_detected` → IDLE, with `o_enable`=0 from the next cycle. Bytes are ignored.
- **STEP:** `o_enable`=1 for exactly one cycle → IDLE. Bytes are ignored.
- `o_enable`=0 in IDLE, LOAD and WRITE, so a write strobe and an enable are never simultaneously high.
- `i_halt_detected` is ignored outside RUN. `o_loaded` persists across runs; only 'L' or reset clears it.

## Timing
- Reset (asynchronous, any state):
  - state = IDLE; all outputs = 0, including `o_instruction_write`.
  - Partial word and byte index are discarded.
- Output registers:
  - `o_flag_instruction_write` and `o_enable` are registered state decodes (Moore), with no combinational path from inputs.
  - `o_busy` = 1 in LOAD, WRITE, RUN and STEP.
- Load latency: the strobe is asserted the cycle after the clock edge that samples the 4th `i_rx_valid`.
- Counter timing: `o_instr_count` updates on the edge that ends WRITE. It equals the index of the next word to write, which is the address the memory uses.
- Command latency: command byte sampled at edge N → `o_enable` high in cycle N+1.
  - STEP: high for one cycle only.
  - RUN: high until the cycle after `i_halt_detected` is sampled.
- Minimum byte spacing is 1 cycle; a `i_rx_valid` pulse held on consecutive cycles counts as separate bytes.

## Test plan
- Reset, then 'L' followed by bytes 20 08 00 05 FF FF FF FF:
  - Write 0x2008_0005 then 0xFFFF_FFFF, each strobe exactly one cycle.
  - `o_instr_count`=2, `o_loaded`=1, `o_enable` never high.
- 'S' after load: `o_enable` high for exactly one cycle, then IDLE. 'S' before any load: `o_error`=1, `o_enable` stays 0.
- 'R' after load: `o_enable` stays high. Pulse `i_halt_detected` at cycle 10 → `o_enable` low at cycle 11, `o_busy`=0.
- Back-to-back bytes on consecutive cycles, 8 words ending in `HALT_WORD`: all 8 writes occur with correct MSB-first words and no byte loss.
- `MAX_INSTR`=4, 4 words with no halt: 4th strobe, then `o_error`=1, `o_loaded`=0, IDLE.
- Assert `i_reset` mid-word (after 2 bytes) and during RUN: immediate return to IDLE with all outputs 0. A subsequent full load starts at count 0 with a fresh byte index.

Source files
------------

// File: rtl/debug_loader.sv
// rtl/debug_loader.sv - byte-stream program loader and run/step controller for the fetch stage
//
// Ports:
//   i_clk                    clock, all state on rising edge
//   i_reset                  asynchronous active-high reset, clears all state
//   i_rx_data                received byte (command in IDLE, program byte in LOAD/WRITE)
//   i_rx_valid               one-cycle pulse qualifying i_rx_data
//   i_halt_detected          pipeline retired HALT_WORD; ends RUN
//   o_instruction_write      assembled instruction word for program memory
//   o_flag_instruction_write one-cycle write strobe (WRITE state)
//   o_enable                 PC/pipeline enable (RUN, or one cycle of STEP)
//   o_instr_count            words written in the current load (next write address)
//   o_loaded                 a complete program ending in HALT_WORD is present
//   o_busy                   controller is not IDLE
//   o_error                  sticky error (bad command, run/step unloaded, overflow)

module debug_loader #(
  parameter int                      SIZE_REG_MEM = 32,
  parameter int                      SIZE_BYTE    = 8,
  parameter int                      MAX_INSTR    = 256,
  parameter int                      SIZE_CNT     = 9,
  parameter logic [SIZE_REG_MEM-1:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [SIZE_BYTE-1:0]    i_rx_data,
  input  logic                    i_rx_valid,
  input  logic                    i_halt_detected,
  output logic [SIZE_REG_MEM-1:0] o_instruction_write,
  output logic                    o_flag_instruction_write,
  output logic                    o_enable,
  output logic [SIZE_CNT-1:0]     o_instr_count,
  output logic                    o_loaded,
  output logic                    o_busy,
  output logic                    o_error
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_STEP  = 3'd4;

  localparam logic [SIZE_BYTE-1:0] CMD_LOAD = SIZE_BYTE'('h4C);
  localparam logic [SIZE_BYTE-1:0] CMD_RUN  = SIZE_BYTE'('h52);
  localparam logic [SIZE_BYTE-1:0] CMD_STEP = SIZE_BYTE'('h53);

  localparam logic [1:0]          LAST_IDX = 2'd3;
  localparam logic [SIZE_CNT-1:0] MAX_CNT  = SIZE_CNT'(MAX_INSTR);

  logic [2:0]              state_q;
  logic [SIZE_REG_MEM-1:0] word_q;
  logic [1:0]              idx_q;
  logic [SIZE_CNT-1:0]     cnt_q;
  logic                    loaded_q;
  logic                    error_q;

  logic [SIZE_REG_MEM-1:0] word_shift;
  logic [SIZE_CNT-1:0]     cnt_inc;

  // Big-endian assembly: earlier bytes migrate toward the MSB.
  assign word_shift = {word_q[SIZE_REG_MEM-SIZE_BYTE-1:0], i_rx_data};
  assign cnt_inc    = cnt_q + SIZE_CNT'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_LOAD) begin
              cnt_q    <= '0;
              loaded_q <= 1'b0;
              error_q  <= 1'b0;
              idx_q    <= '0;
              state_q  <= ST_LOAD;
            end else if (i_rx_data == CMD_RUN && loaded_q) begin
              state_q <= ST_RUN;
            end else if (i_rx_data == CMD_STEP && loaded_q) begin
              state_q <= ST_STEP;
            end else begin
              error_q <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (i_rx_valid) begin
            word_q <= word_shift;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          cnt_q <= cnt_inc;
          if (word_q == HALT_WORD) begin
            loaded_q <= 1'b1;
            state_q  <= ST_IDLE;
          end else if (cnt_inc == MAX_CNT) begin
            error_q  <= 1'b1;
            loaded_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            state_q <= ST_LOAD;
            // A byte arriving while the strobe is up is the first byte of the
            // next word; word_q is only consumed during this cycle, so it can
            // start shifting at the closing edge.
            if (i_rx_valid) begin
              word_q <= word_shift;
              idx_q  <= idx_q + 2'd1;
            end
          end
        end

        ST_RUN: begin
          if (i_halt_detected) begin
            state_q <= ST_IDLE;
          end
        end

        ST_STEP: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobe and enable decode only the state register, so they are mutually
  // exclusive and have no path from the receive inputs.
  assign o_flag_instruction_write = (state_q == ST_WRITE);
  assign o_enable                 = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign o_busy                   = (state_q != ST_IDLE);
  assign o_instruction_write      = word_q;
  assign o_instr_count            = cnt_q;
  assign o_loaded                 = loaded_q;
  assign o_error                  = error_q;

endmodule

// File: tb/tb_debug_loader.sv
// tb/tb_debug_loader.sv - scoreboard bench for debug_loader
module tb_debug_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid_a, rx_valid_b;
  logic        halt_a, halt_b;

  logic [31:0] word_a, word_b;
  logic        flag_a, flag_b, en_a, en_b, loaded_a, loaded_b;
  logic        busy_a, busy_b, err_a, err_b;
  logic [8:0]  cnt_a, cnt_b;

  debug_loader dut_a (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid_a),
    .i_halt_detected(halt_a), .o_instruction_write(word_a),
    .o_flag_instruction_write(flag_a), .o_enable(en_a), .o_instr_count(cnt_a),
    .o_loaded(loaded_a), .o_busy(busy_a), .o_error(err_a)
  );

  debug_loader #(.MAX_INSTR(4)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid_b),
    .i_halt_detected(halt_b), .o_instruction_write(word_b),
    .o_flag_instruction_write(flag_b), .o_enable(en_b), .o_instr_count(cnt_b),
    .o_loaded(loaded_b), .o_busy(busy_b), .o_error(err_b)
  );

  // flag bits: {flag, enable, busy, loaded, error}
  typedef struct packed {
    logic [31:0] word;
    logic [8:0]  cnt;
    logic [4:0]  f;
  } st_t;

  typedef struct {
    logic [31:0] word;
    logic [8:0]  cnt;
  } wr_t;

  typedef struct {
    logic [159:0] name;
    bit           sel;
    bit           kind;
    st_t          mask;
    st_t          val;
  } exp_t;

  localparam st_t M_ALL   = '1;
  localparam st_t M_STAT  = {32'h0, 9'h000, 5'h1F};
  localparam st_t M_STATC = {32'h0, 9'h1FF, 5'h1F};
  localparam st_t M_FEB   = {32'h0, 9'h000, 5'b11100};

  wr_t  wr_a[$];
  wr_t  wr_b[$];
  exp_t st_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  st_t obs_a, obs_b;
  assign obs_a = {word_a, cnt_a, flag_a, en_a, busy_a, loaded_a, err_a};
  assign obs_b = {word_b, cnt_b, flag_b, en_b, busy_b, loaded_b, err_b};

  function automatic st_t mk(input logic [8:0] c, input logic [4:0] f);
    mk = {32'h0, c, f};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic check_wr(input bit sel, input logic f, input logic e,
                          input logic [31:0] w, input logic [8:0] c, input logic pf);
    wr_t x;
    int  pending;
    if (!f) return;
    pending = sel ? wr_b.size() : wr_a.size();
    n_checks++;
    if (pending == 0) begin
      n_fail++;
      $display("FAIL write_unexpected dut %0d: got word %h cnt %0d, required no write", sel, w, c);
    end else begin
      if (sel) x = wr_b.pop_front();
      else     x = wr_a.pop_front();
      if (x.word !== w || x.cnt !== c) begin
        n_fail++;
        $display("FAIL write_data dut %0d: got word %h cnt %0d, required word %h cnt %0d",
                 sel, w, c, x.word, x.cnt);
      end
    end
    n_checks++;
    if (e !== 1'b0) begin
      n_fail++;
      $display("FAIL write_enable_overlap dut %0d: got enable %b, required 0", sel, e);
    end
    n_checks++;
    if (pf !== 1'b0) begin
      n_fail++;
      $display("FAIL write_strobe_width dut %0d: got strobe high 2 cycles, required 1", sel);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    st_t  o;
    check_wr(1'b0, flag_a, en_a, word_a, cnt_a, prev_a);
    check_wr(1'b1, flag_b, en_b, word_b, cnt_b, prev_b);
    prev_a = flag_a;
    prev_b = flag_b;
    while (st_q.size() != 0) begin
      e = st_q.pop_front();
      n_checks++;
      if (e.kind) begin
        if (wr_a.size() != 0 || wr_b.size() != 0) begin
          n_fail++;
          $display("FAIL %0s: got pending writes a=%0d b=%0d, required 0 and 0",
                   e.name, wr_a.size(), wr_b.size());
        end
      end else begin
        o = e.sel ? obs_b : obs_a;
        if ((o & e.mask) !== (e.val & e.mask)) begin
          n_fail++;
          $display("FAIL %0s dut %0d: got %h, required %h (mask %h)",
                   e.name, e.sel, o & e.mask, e.val & e.mask, e.mask);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input logic [159:0] name, input bit sel, input st_t mask, input st_t val);
    exp_t e;
    e.name = name; e.sel = sel; e.kind = 1'b0; e.mask = mask; e.val = val;
    st_q.push_back(e);
  endtask

  task automatic expect_empty();
    exp_t e;
    e.name = "all_writes_seen"; e.sel = 1'b0; e.kind = 1'b1; e.mask = '0; e.val = '0;
    st_q.push_back(e);
  endtask

  task automatic push_wr(input bit sel, input logic [31:0] w, input logic [8:0] c);
    wr_t x;
    x.word = w; x.cnt = c;
    if (sel) wr_b.push_back(x);
    else     wr_a.push_back(x);
  endtask

  task automatic send(input bit sel, input logic [7:0] b);
    rx_data = b;
    if (sel) rx_valid_b = 1'b1;
    else     rx_valid_a = 1'b1;
    tick();
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  // MSB first; the strobe must be up in the cycle right after the 4th byte.
  task automatic send_word(input bit sel, input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) begin
      send(sel, w[8*i +: 8]);
      expect_st("load_byte", sel, M_FEB, mk(9'd0, {(i == 0), 1'b0, 1'b1, 2'b00}));
      if (gap) tick();
    end
  endtask

  logic [31:0] words[8];
  logic [31:0] ov[4];

  initial begin
    words[0] = 32'h0123_4567; words[1] = 32'h89AB_CDEF;
    words[2] = 32'hDEAD_BEEF; words[3] = 32'h0000_0000;
    words[4] = 32'hA5A5_5A5A; words[5] = 32'h1200_0034;
    words[6] = 32'h0F0F_F0F0; words[7] = 32'hFFFF_FFFF;
    ov[0] = 32'h1111_1111; ov[1] = 32'h2222_2222;
    ov[2] = 32'h3333_3333; ov[3] = 32'h4444_4444;

    rst = 1'b1; rx_data = 8'h00; rx_valid_a = 1'b0; rx_valid_b = 1'b0;
    halt_a = 1'b0; halt_b = 1'b0;
    tick();
    expect_st("reset_a", 1'b0, M_ALL, '0);
    expect_st("reset_b", 1'b1, M_ALL, '0);
    tick();
    rst = 1'b0;
    tick();

    // step with nothing loaded
    send(1'b0, 8'h53);
    expect_st("step_unloaded", 1'b0, M_STAT, mk(9'd0, 5'b00001));
    tick();
    expect_st("step_unloaded_hold", 1'b0, M_STAT, mk(9'd0, 5'b00001));

    // spaced load of two words
    send(1'b0, 8'h4C);
    expect_st("load_entry", 1'b0, M_STAT, mk(9'd0, 5'b00100));
    tick();
    push_wr(1'b0, 32'h2008_0005, 9'd0);
    push_wr(1'b0, 32'hFFFF_FFFF, 9'd1);
    send_word(1'b0, 32'h2008_0005, 1'b1);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b1);
    expect_st("load_done", 1'b0, M_STATC, mk(9'd2, 5'b00010));

    // single step
    send(1'b0, 8'h53);
    expect_st("step_enable", 1'b0, M_STAT, mk(9'd0, 5'b01110));
    tick();
    expect_st("step_done", 1'b0, M_STAT, mk(9'd0, 5'b00010));
    tick();
    expect_st("step_stays_low", 1'b0, M_STAT, mk(9'd0, 5'b00010));

    // run until halt pulse in cycle 10
    send(1'b0, 8'h52);
    for (int i = 0; i < 9; i++) begin
      expect_st("run_enable", 1'b0, M_STAT, mk(9'd0, 5'b01110));
      tick();
    end
    halt_a = 1'b1;
    expect_st("run_halt_cycle", 1'b0, M_STAT, mk(9'd0, 5'b01110));
    tick();
    halt_a = 1'b0;
    expect_st("run_stopped", 1'b0, M_STAT, mk(9'd0, 5'b00010));
    tick();
    expect_st("run_stays_stopped", 1'b0, M_STAT, mk(9'd0, 5'b00010));
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    expect_st("halt_ignored_idle", 1'b0, M_STATC, mk(9'd2, 5'b00010));

    // back-to-back bytes, 8 words
    send(1'b0, 8'h4C);
    for (int k = 0; k < 8; k++) push_wr(1'b0, words[k], 9'(k));
    for (int k = 0; k < 8; k++) send_word(1'b0, words[k], 1'b0);
    tick();
    expect_st("b2b_done", 1'b0, M_STATC, mk(9'd8, 5'b00010));

    // capacity overflow on the 4-word instance
    send(1'b1, 8'h4C);
    for (int k = 0; k < 4; k++) push_wr(1'b1, ov[k], 9'(k));
    for (int k = 0; k < 4; k++) send_word(1'b1, ov[k], 1'b0);
    tick();
    expect_st("overflow", 1'b1, M_STATC, mk(9'd4, 5'b00001));
    send(1'b1, 8'h52);
    expect_st("overflow_no_run", 1'b1, M_STAT, mk(9'd0, 5'b00001));
    tick();

    // reset after two bytes of a word
    send(1'b0, 8'h4C);
    send(1'b0, 8'hAA);
    send(1'b0, 8'hBB);
    rst = 1'b1;
    expect_st("reset_midword_a", 1'b0, M_ALL, '0);
    expect_st("reset_midword_b", 1'b1, M_ALL, '0);
    tick();
    rst = 1'b0;
    tick();
    push_wr(1'b0, 32'hCAFE_F00D, 9'd0);
    push_wr(1'b0, 32'hFFFF_FFFF, 9'd1);
    send(1'b0, 8'h4C);
    send_word(1'b0, 32'hCAFE_F00D, 1'b0);
    send_word(1'b0, 32'hFFFF_FFFF, 1'b0);
    tick();
    expect_st("reload_done", 1'b0, M_STATC, mk(9'd2, 5'b00010));

    // reset during run
    send(1'b0, 8'h52);
    tick();
    expect_st("run_before_reset", 1'b0, M_STAT, mk(9'd0, 5'b01110));
    tick();
    rst = 1'b1;
    expect_st("reset_run", 1'b0, M_ALL, '0);
    tick();
    rst = 1'b0;
    tick();
    expect_st("after_reset_idle", 1'b0, M_ALL, '0);
    send(1'b0, 8'h53);
    expect_st("step_after_reset", 1'b0, M_STAT, mk(9'd0, 5'b00001));
    tick();

    expect_empty();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
